// File: rtl/ame_num_pkg.sv
// Shared types for the ame power-of-two apply block: operation mode and
// the per-stage pipeline record carried between S1, S2 and S3.
package ame_num_pkg;

  localparam int AME_DATA_BITS = 64;
  localparam int AME_SHFT_BITS = $clog2(AME_DATA_BITS);

  typedef enum logic {
    AME_MUL = 1'b0,
    AME_DIV = 1'b1
  } ame_mode_e;

  // data is one bit wider than the operand so the rounding bias never overflows.
  typedef struct packed {
    logic                     valid;
    logic [AME_SHFT_BITS-1:0] k;
    logic                     zero;
    logic                     multi;
    ame_mode_e                mode;
    logic                     sign;
    logic [AME_DATA_BITS:0]   data;
  } ame_stage_t;

endpackage

// File: rtl/ame_pri_enc_8b.sv
// 8-bit priority encoder: index of the highest set bit plus an any-set flag.
module ame_pri_enc_8b (
  input  logic [7:0] bits,
  output logic [2:0] idx,
  output logic       any
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (bits[i]) idx = 3'(i);
    end
  end

  assign any = |bits;

endmodule

// File: rtl/ame_num_apply.sv
// Applies a sign + one-hot power-of-two factor to a signed operand as a
// shift-only multiply or rounded divide, in a 3-stage pipeline.
module ame_num_apply
  import ame_num_pkg::*;
#(
  parameter int  COMP_DATA_BITS = AME_DATA_BITS,
  localparam int SHFT_BITS      = $clog2(COMP_DATA_BITS)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      comp_init_i,
  input  logic                      comp_mode_i,
  input  logic                      comp_sign_i,
  input  logic [COMP_DATA_BITS-1:0] comp_apx_i,
  input  logic [COMP_DATA_BITS-1:0] comp_data_i,
  output logic                      comp_done_o,
  output logic [COMP_DATA_BITS-1:0] comp_data_o,
  output logic [SHFT_BITS-1:0]      comp_shft_o,
  output logic                      comp_err_o
);

  localparam int NBYTES = COMP_DATA_BITS / 8;
  localparam int IW     = AME_DATA_BITS + 1;

  // S1: encode
  logic [NBYTES-1:0][2:0]   byte_idx;
  logic [NBYTES-1:0]        byte_any;
  logic [AME_SHFT_BITS-1:0] enc_k;
  logic                     apx_multi;
  ame_stage_t               s1_next;
  ame_stage_t               s1;

  for (genvar g = 0; g < NBYTES; g++) begin : g_enc
    ame_pri_enc_8b u_enc (
      .bits (comp_apx_i[8*g +: 8]),
      .idx  (byte_idx[g]),
      .any  (byte_any[g])
    );
  end

  // Highest non-empty byte wins; its local index forms the low three bits of k.
  always_comb begin
    enc_k = '0;
    for (int g = 0; g < NBYTES; g++) begin
      if (byte_any[g]) enc_k = AME_SHFT_BITS'(g * 8) | AME_SHFT_BITS'(byte_idx[g]);
    end
  end

  assign apx_multi = |(comp_apx_i & (comp_apx_i - COMP_DATA_BITS'(1)));

  always_comb begin
    s1_next       = '0;
    s1_next.valid = comp_init_i;
    s1_next.k     = enc_k;
    s1_next.zero  = ~|comp_apx_i;
    s1_next.multi = apx_multi;
    s1_next.mode  = ame_mode_e'(comp_mode_i);
    s1_next.sign  = comp_sign_i;
    s1_next.data  = IW'($signed(comp_data_i));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) s1 <= '0;
    else          s1 <= s1_next;
  end

  // S2: rounding bias and byte-granular shift
  logic [AME_SHFT_BITS-1:0] coarse_amt;
  logic signed [IW-1:0]     s2_bias;
  logic signed [IW-1:0]     s2_shift;
  ame_stage_t               s2_next;
  ame_stage_t               s2;

  always_comb begin
    coarse_amt = s1.k & ~AME_SHFT_BITS'(7);
    s2_bias    = s1.data;
    if (s1.mode == AME_DIV && s1.k != '0)
      s2_bias = s1.data + (IW'(1) << (s1.k - AME_SHFT_BITS'(1)));
    s2_shift = (s1.mode == AME_MUL) ? (s2_bias << coarse_amt) : (s2_bias >>> coarse_amt);
    s2_next      = s1;
    s2_next.data = s2_shift;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) s2 <= '0;
    else          s2 <= s2_next;
  end

  // S3: bit-granular shift, sign, truncate
  logic signed [IW-1:0]      s3_in;
  logic signed [IW-1:0]      s3_shift;
  logic signed [IW-1:0]      s3_val;
  logic [COMP_DATA_BITS-1:0] s3_res;
  logic                      s3_div_zero;

  always_comb begin
    s3_in       = s2.data;
    s3_shift    = (s2.mode == AME_MUL) ? (s3_in << s2.k[2:0]) : (s3_in >>> s2.k[2:0]);
    s3_val      = s2.sign ? -s3_shift : s3_shift;
    s3_res      = s2.zero ? '0 : COMP_DATA_BITS'(s3_val);
    s3_div_zero = s2.zero && (s2.mode == AME_DIV);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      comp_done_o <= 1'b0;
      comp_data_o <= '0;
      comp_shft_o <= '0;
      comp_err_o  <= 1'b0;
    end else begin
      comp_done_o <= s2.valid;
      if (s2.valid) begin
        comp_data_o <= s3_res;
        comp_shft_o <= s3_div_zero ? '0 : SHFT_BITS'(s2.k);
        comp_err_o  <= s2.multi | s3_div_zero;
      end
    end
  end

endmodule

// File: tb/tb_ame_num_apply.sv
// Bench for ame_num_apply: vector table, random model vectors, latency,
// streaming, hold and mid-pipeline reset sequences.
module tb_ame_num_apply;

  localparam int W  = 64;
  localparam int SW = 6;
  localparam int EW = 1 + SW + W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          comp_init = 1'b0;
  logic          comp_mode = 1'b0;
  logic          comp_sign = 1'b0;
  logic [W-1:0]  comp_apx = '0;
  logic [W-1:0]  comp_data = '0;
  logic          comp_done;
  logic [W-1:0]  comp_data_out;
  logic [SW-1:0] comp_shft;
  logic          comp_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [EW-1:0] exp_q[$];

  ame_num_apply #(.COMP_DATA_BITS(W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .comp_init_i (comp_init),
    .comp_mode_i (comp_mode),
    .comp_sign_i (comp_sign),
    .comp_apx_i  (comp_apx),
    .comp_data_i (comp_data),
    .comp_done_o (comp_done),
    .comp_data_o (comp_data_out),
    .comp_shft_o (comp_shft),
    .comp_err_o  (comp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic          sign;
    logic [W-1:0]  apx;
    logic [W-1:0]  data;
    logic [W-1:0]  exp_data;
    logic [SW-1:0] exp_shft;
    logic          exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: true multiply by 2^k, or floor((x + 2^(k-1)) / 2^k) by integer division.
  function automatic logic [EW-1:0] model(input logic mode, input logic sign,
                                          input logic [W-1:0] apx, input logic [W-1:0] data);
    int k;
    logic signed [127:0] x, p, q;
    logic err;
    logic [W-1:0] r;
    k = 0;
    for (int i = 0; i < W; i++) if (apx[i]) k = i;
    err = ($countones(apx) > 1) || (apx == '0 && mode);
    x = 128'($signed(data));
    p = 128'sd1 <<< k;
    if (!mode) q = x * p;
    else begin
      if (k > 0) x = x + p / 2;
      if (x >= 0) q = x / p;
      else        q = -((-x + p - 1) / p);
    end
    if (sign) q = -q;
    r = q[W-1:0];
    if (apx == '0) begin
      r = '0;
      k = 0;
    end
    return {err, SW'(k), r};
  endfunction

  task automatic drive_op(input logic mode, input logic sign, input logic [W-1:0] apx,
                          input logic [W-1:0] data, input logic [EW-1:0] exp);
    @(posedge clk); #1;
    comp_init = 1'b1;
    comp_mode = mode;
    comp_sign = sign;
    comp_apx  = apx;
    comp_data = data;
    exp_q.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      comp_init = 1'b0;
      comp_apx  = $urandom;
      comp_data = {$urandom, $urandom};
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(posedge clk); #1;
      comp_init = 1'b0;
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: every done pulse pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && comp_done) begin
      logic [EW-1:0] e;
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result: unexpected done, data=%h shft=%0d err=%b expected no pulse",
                 comp_data_out, comp_shft, comp_err);
      end else begin
        e = exp_q.pop_front();
        if ({comp_err, comp_shft, comp_data_out} !== e) begin
          errors++;
          $display("FAIL result: data=%h shft=%0d err=%b expected data=%h shft=%0d err=%b",
                   comp_data_out, comp_shft, comp_err, e[W-1:0], e[W+SW-1:W], e[EW-1]);
        end
      end
    end
  end

  initial begin
    int lat;
    int done_before;

    vecs[0]  = '{1'b0, 1'b0, 64'h10, 64'd3, 64'd48, 6'd4, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 64'h4, -64'sd7, -64'sd2, 6'd2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 64'h4, 64'd6, 64'd2, 6'd2, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 64'h100, 64'd5, -64'sd1280, 6'd8, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 6'd0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 64'h0, 64'd123, 64'd0, 6'd0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 64'h18, 64'd1, 64'd16, 6'd4, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 64'h0, 64'd77, 64'd0, 6'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 64'h100, 64'd1000, -64'sd4, 6'd8, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 64'h1, -64'sd5, -64'sd5, 6'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 6'd63, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 64'h0000_0800_0000_0000, 64'd3, 64'h0000_1800_0000_0000, 6'd43, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd63, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, -64'sd1, 6'd63, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 64'h2, 64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 64'h1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'd0, 1'b0};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 64'(comp_done), 64'd0);
    check("reset_data", comp_data_out, 64'd0);
    check("reset_shft", 64'(comp_shft), 64'd0);
    check("reset_err",  64'(comp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Latency and single-pulse on the first table vector
    drive_op(vecs[0].mode, vecs[0].sign, vecs[0].apx, vecs[0].data,
             {vecs[0].exp_err, vecs[0].exp_shft, vecs[0].exp_data});
    @(posedge clk); #1;
    comp_init = 1'b0;
    lat = 1;
    while (!comp_done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd3);
    @(posedge clk); #1;
    check("done_single_pulse", 64'(comp_done), 64'd0);
    drain();

    // Table, back to back
    for (int i = 1; i < 16; i++)
      drive_op(vecs[i].mode, vecs[i].sign, vecs[i].apx, vecs[i].data,
               {vecs[i].exp_err, vecs[i].exp_shft, vecs[i].exp_data});
    idle(1);
    drain();

    // Random vectors against the model, with gaps
    for (int i = 0; i < 24; i++) begin
      logic m, s;
      logic [W-1:0] a, d;
      m = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       a = '0;
        1:       a = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
        default: a = 64'd1 << $urandom_range(0, 63);
      endcase
      drive_op(m, s, a, d, model(m, s, a, d));
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(1);
    drain();

    // Streaming then hold
    done_before = done_cnt;
    drive_op(1'b0, 1'b0, 64'h2, 64'd1, {1'b0, 6'd1, 64'd2});
    drive_op(1'b0, 1'b0, 64'h4, 64'd1, {1'b0, 6'd2, 64'd4});
    drive_op(1'b0, 1'b0, 64'h8, 64'd1, {1'b0, 6'd3, 64'd8});
    idle(6);
    check("stream_pulses", 64'(done_cnt - done_before), 64'd3);
    check("hold_done", 64'(comp_done), 64'd0);
    check("hold_data", comp_data_out, 64'd8);
    check("hold_shft", 64'(comp_shft), 64'd3);
    check("hold_err",  64'(comp_err), 64'd0);

    // Reset mid-pipe: the in-flight op must vanish
    done_before = done_cnt;
    @(posedge clk); #1;
    comp_init = 1'b1;
    comp_mode = 1'b0;
    comp_sign = 1'b0;
    comp_apx  = 64'h10;
    comp_data = 64'd9;
    @(posedge clk); #1;
    comp_init = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_done", 64'(comp_done), 64'd0);
    check("rst_mid_data", comp_data_out, 64'd0);
    check("rst_mid_shft", 64'(comp_shft), 64'd0);
    check("rst_mid_err",  64'(comp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    check("rst_mid_no_pulse", 64'(done_cnt - done_before), 64'd0);

    // Normal op after reset release
    drive_op(1'b1, 1'b0, 64'h4, 64'd6, {1'b0, 6'd2, 64'd2});
    @(posedge clk); #1;
    comp_init = 1'b0;
    lat = 1;
    while (!comp_done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("post_rst_latency", 64'(lat), 64'd3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ame_num_apply.md
Name: ame_num_apply

Overview:
- Consumes a power-of-two approximation: a one-hot unsigned magnitude plus a separate sign bit.
- Applies that approximation to a signed operand as a shift-only multiply or rounded divide, so affine ME parameter derivation needs no hardware multiplier or divider.
- 3-stage pipeline; accepts one operation per cycle.
- Uses the same comp_init/comp_done handshake style as the other ame arithmetic blocks.

Parameters:
- COMP_DATA_BITS, 64, width of operand, approximation and result. Must be a multiple of 8, range 8..64.
- SHFT_BITS (localparam), $clog2(COMP_DATA_BITS), width of the shift index.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- comp_init_i  in  1  start; one operation per cycle when high
- comp_mode_i  in  1  0 = multiply (left shift), 1 = divide (rounded arithmetic right shift)
- comp_sign_i  in  1  sign of the approximated factor (1 = negative)
- comp_apx_i  in  COMP_DATA_BITS  unsigned approximation magnitude, nominally one-hot or zero
- comp_data_i  in  COMP_DATA_BITS  signed operand
- comp_done_o  out  1  one-cycle pulse, result valid
- comp_data_o  out  COMP_DATA_BITS  signed result
- comp_shft_o  out  SHFT_BITS  shift index k actually applied
- comp_err_o  out  1  set when apx had more than one bit set, or apx = 0 in divide mode

Behaviour:
- Reset: all pipeline registers, comp_done_o, comp_data_o, comp_shft_o and comp_err_o clear to 0. No other state.
- Latency: comp_init_i high at edge N gives comp_done_o high after edge N+3, for exactly one cycle per init.
- Throughput: back-to-back inits allowed; each init produces its own done pulse 3 cycles later.
- Hold: when no done pulse, comp_data_o, comp_shft_o and comp_err_o hold their last values.
- S1 (encode):
  - Find the highest set bit index k of comp_apx_i, using per-byte 8-bit encoders plus a group priority select.
  - Register k, zero flag (apx == 0), multi flag (popcount > 1), mode, sign and data.
  - Stage valid = comp_init_i.
- S2 (bias + coarse shift):
  - Internal width COMP_DATA_BITS+1, sign-extended.
  - Divide mode with k > 0: add bias 2^(k-1) (round half toward +inf).
  - Then shift by 8*k[SHFT_BITS-1:3]: left in multiply mode, arithmetic right in divide mode.
- S3 (fine shift + sign + output):
  - Shift by k[2:0] in the mode's direction, then negate if sign = 1.
  - Truncate to COMP_DATA_BITS: multiply overflow wraps, and negating the most-negative value wraps.
  - Drive comp_data_o, comp_shft_o = k, comp_done_o.
- Zero approximation:
  - Multiply mode: result 0, err 0.
  - Divide mode: result 0, err 1, comp_shft_o = 0.
- Multi-bit approximation: computed with the highest set bit, err 1.
- k = 0: result = ±data, no bias applied.
- Reset mid-operation: in-flight operations are discarded and no done pulse is emitted for them.
- comp_init_i is sampled only on clock edges; inputs are don't-care when it is low.

Decomposition:
- Package ame_num_pkg:
  - COMP_DATA_BITS default constant.
  - Mode typedef (AME_MUL = 1'b0, AME_DIV = 1'b1).
  - Per-stage pipeline struct typedef (valid, k, zero, multi, mode, sign, data).
- Sub-module ame_pri_enc_8b: one-hot/priority 8-bit to 3-bit index plus any-set flag, instantiated COMP_DATA_BITS/8 times in S1.

Test Plan:
- Multiply: mode=0, sign=0, apx=0x10, data=3, init at N -> done at N+3, data_o=48, shft_o=4, err_o=0.
- Divide rounding: mode=1, apx=0x4, data=-7 -> data_o=-2, shft_o=2. Also data=6, apx=0x4 -> data_o=2 (1.5 rounds up).
- Negative factor: mode=0, sign=1, apx=0x100, data=5 -> data_o=-1280, shft_o=8. Also apx=1, data=0x7FFF_FFFF_FFFF_FFFF, sign=1 -> data_o=0x8000_0000_0000_0001.
- Error cases: apx=0 in divide mode -> data_o=0, err_o=1. apx=0x18, data=1, multiply -> data_o=16, shft_o=4, err_o=1. apx=0 in multiply mode -> data_o=0, err_o=0.
- Streaming: inits on 3 consecutive cycles (apx=0x2, 0x4, 0x8, data=1, multiply) -> 3 consecutive done pulses with data_o 2, 4, 8. Outputs hold thereafter.
- Reset mid-pipe: init at N, rst_n_i low between N+1 and N+2 -> no done pulse, outputs 0. An init after reset release completes normally with latency 3.
